// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory responder.
//   dm_state_t        : CLEAR (post-reset zeroing sweep) / READY (servicing accesses)
//   DM_DEFAULT_DEPTH  : default number of words
//   DM_WORD_W         : data word width
package data_mem_pkg;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

  localparam int DM_DEFAULT_DEPTH = 256;
  localparam int DM_WORD_W        = 16;

endpackage

// File: rtl/data_mem_array.sv
// Word storage for the data memory: one synchronous write port, one
// asynchronous read port. No reset; the parent zeroes it with a sweep.
// Ports:
//   clock  : write clock (rising edge)
//   we     : write enable
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : read data (combinational)
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH     = DM_DEFAULT_DEPTH,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DM_WORD_W-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DM_WORD_W-1:0] rdata
);

  logic [DM_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the CPU load/store port. After every reset
// a CLEAR sweep writes zero to each word (busy=1, accesses ignored); then it
// services loads (combinational read) and stores (rising-edge write) in READY.
// Out-of-range enabled accesses in READY set a sticky addr_error.
// Optional feature macro: DATA_MEM_ACCESS_COUNT_EN adds saturating
// read_count / write_count ports counting completed in-range loads/stores.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   mem_enable           : access request
//   mem_write_enable     : store when set with mem_enable, else load
//   data_mem_addr        : word address
//   data_mem_write_data  : store data
//   data_mem_read_data   : load data (0 unless a valid in-range load)
//   busy                 : clear sweep in progress
//   addr_error           : sticky out-of-range flag
//   read_count/write_count (macro only) : access counters
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH     = DM_DEFAULT_DEPTH,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_enable,
  input  logic                 mem_write_enable,
  input  logic [DM_WORD_W-1:0] data_mem_addr,
  input  logic [DM_WORD_W-1:0] data_mem_write_data,
  output logic [DM_WORD_W-1:0] data_mem_read_data,
  output logic                 busy,
  output logic                 addr_error
`ifdef DATA_MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]          read_count,
  output logic [15:0]          write_count
`endif
);

  dm_state_t            state, state_next;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS-1:0] index;
  logic                 in_range, ready, clearing, ptr_last;
  logic                 load_ok, store_ok, bad_access;
  logic                 arr_we;
  logic [ADDR_BITS-1:0] arr_waddr;
  logic [DM_WORD_W-1:0] arr_wdata, arr_rdata;

  assign in_range   = (data_mem_addr >> ADDR_BITS) == '0;
  assign index      = data_mem_addr[ADDR_BITS-1:0];
  assign ready      = (state == DM_READY);
  assign clearing   = (state == DM_CLEAR) && !reset;
  assign ptr_last   = (ptr == ADDR_BITS'(DEPTH - 1));
  assign load_ok    = ready && mem_enable && !mem_write_enable && in_range;
  assign store_ok   = ready && mem_enable && mem_write_enable && in_range && !reset;
  assign bad_access = ready && mem_enable && !in_range;

  always_ff @(posedge clock) begin
    if (reset) state <= DM_CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DM_CLEAR: if (ptr_last) state_next = DM_READY;
      DM_READY: state_next = DM_READY;
      default:  state_next = DM_CLEAR;
    endcase
  end

  // Pointer wraps back to 0 on the final sweep write, ready for the next reset.
  always_ff @(posedge clock) begin
    if (reset)         ptr <= '0;
    else if (clearing) ptr <= ptr + ADDR_BITS'(1);
  end

  // Single write port shared between the clear sweep and CPU stores.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = index;
    arr_wdata = data_mem_write_data;
    if (clearing) begin
      arr_we    = 1'b1;
      arr_waddr = ptr;
      arr_wdata = '0;
    end else if (store_ok) begin
      arr_we    = 1'b1;
    end
  end

  data_mem_array #(
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clock(clock),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(index),
    .rdata(arr_rdata)
  );

  assign data_mem_read_data = load_ok ? arr_rdata : '0;
  assign busy               = (state == DM_CLEAR);

  always_ff @(posedge clock) begin
    if (reset)           addr_error <= 1'b0;
    else if (bad_access) addr_error <= 1'b1;
  end

`ifdef DATA_MEM_ACCESS_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (load_ok  && read_count  != '1) read_count  <= read_count  + 16'd1;
      if (store_ok && write_count != '1) write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int K_RD = 0, K_BUSY = 1, K_ERR = 2, K_RCNT = 3, K_WCNT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_enable, mem_write_enable;
  logic [15:0] data_mem_addr, data_mem_write_data;
  logic [15:0] data_mem_read_data;
  logic        busy, addr_error;
`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [15:0] read_count, write_count;
`endif

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .mem_enable         (mem_enable),
    .mem_write_enable   (mem_write_enable),
    .data_mem_addr      (data_mem_addr),
    .data_mem_write_data(data_mem_write_data),
    .data_mem_read_data (data_mem_read_data),
    .busy               (busy),
    .addr_error         (addr_error)
`ifdef DATA_MEM_ACCESS_COUNT_EN
    ,
    .read_count         (read_count),
    .write_count        (write_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_rd = 0;
  int   n_wr = 0;
  bit   in_ready = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t        e;
      logic [15:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RD:    act = data_mem_read_data;
        K_BUSY:  act = {15'd0, busy};
        K_ERR:   act = {15'd0, addr_error};
`ifdef DATA_MEM_ACCESS_COUNT_EN
        K_RCNT:  act = read_count;
        K_WCNT:  act = write_count;
`endif
        default: act = 16'hxxxx;
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h expected %h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic expect_val(int kind, logic [15:0] v, string nm);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic expect_counts();
`ifdef DATA_MEM_ACCESS_COUNT_EN
    expect_val(K_RCNT, 16'(n_rd), "read_count");
    expect_val(K_WCNT, 16'(n_wr), "write_count");
`endif
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic en, logic we, logic [15:0] a, logic [15:0] d);
    mem_enable = en; mem_write_enable = we; data_mem_addr = a; data_mem_write_data = d;
  endtask

  task automatic do_load(logic [15:0] a, logic [15:0] v, string nm);
    drive(1'b1, 1'b0, a, 16'h0);
    expect_val(K_RD, v, nm);
    if (in_ready && a < 16'(DEPTH)) n_rd++;
    step();
  endtask

  task automatic do_store(logic [15:0] a, logic [15:0] d, string nm);
    drive(1'b1, 1'b1, a, d);
    expect_val(K_RD, 16'h0, nm);
    if (in_ready && a < 16'(DEPTH)) n_wr++;
    step();
  endtask

  // Full sweep from ptr=0: busy for DEPTH edges while accesses are thrown at it.
  task automatic sweep(string tag);
    for (int k = 0; k < DEPTH; k++) begin
      expect_val(K_BUSY, 16'd1, {tag, "_busy"});
      case (k % 3)
        0: begin drive(1'b1, 1'b0, 16'd3, 16'h0); expect_val(K_RD, 16'h0, {tag, "_rd_clear"}); end
        1: drive(1'b1, 1'b1, 16'd3, 16'hFFFF);
        default: drive(1'b1, 1'b1, 16'h0100, 16'h5555);
      endcase
      step();
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    expect_val(K_BUSY, 16'd0, {tag, "_busy_fall"});
    expect_val(K_ERR, 16'd0, {tag, "_err_clear"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    step();
    repeat (2) begin
      drive(1'b1, 1'b0, 16'h0, 16'h0);
      expect_val(K_RD, 16'h0, "rst_rd");
      expect_val(K_BUSY, 16'd1, "rst_busy");
      expect_val(K_ERR, 16'd0, "rst_err");
      expect_counts();
      step();
    end
    reset = 1'b0;
    sweep("clr1");

    in_ready = 1;
    do_load(16'd0, 16'h0, "ld0_zero");
    do_load(16'd128, 16'h0, "ld128_zero");
    do_load(16'd255, 16'h0, "ld255_zero");
    do_load(16'd3, 16'h0, "ld3_ignored_store");
    expect_val(K_ERR, 16'd0, "err_after_clear");
    do_store(16'd5, 16'hBEEF, "st5_rd0");
    do_load(16'd5, 16'hBEEF, "ld5_beef");
    do_load(16'd6, 16'h0, "ld6_zero");
    drive(1'b0, 1'b1, 16'd7, 16'h1234);
    expect_val(K_RD, 16'h0, "we_no_en_rd");
    step();
    do_load(16'd7, 16'h0, "ld7_no_write");
    do_store(16'd0, 16'h1111, "st0");
    expect_val(K_ERR, 16'd0, "err_before_oor");
    do_store(16'h0100, 16'h2222, "st_oor");
    expect_val(K_ERR, 16'd1, "err_rise");
    do_load(16'h0100, 16'h0, "ld_oor_zero");
    do_load(16'd0, 16'h1111, "ld0_unchanged");
    expect_val(K_ERR, 16'd1, "err_sticky");
    expect_counts();
    step();

    // Reset in READY, then again mid-sweep at ptr=100.
    reset = 1'b1;
    in_ready = 0; n_rd = 0; n_wr = 0;
    step();
    expect_val(K_BUSY, 16'd1, "rst2_busy");
    expect_val(K_ERR, 16'd0, "rst2_err");
    expect_counts();
    step();
    reset = 1'b0;
    for (int k = 0; k < 100; k++) step();
    expect_val(K_BUSY, 16'd1, "mid_busy");
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep("clr2");
    in_ready = 1;
    do_load(16'd5, 16'h0, "ld5_rezeroed");
    do_load(16'd0, 16'h0, "ld0_rezeroed");
    expect_counts();
    step();
    step();

    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
